// File: rtl/vga_pkg.sv
// Shared constants for the VGA test-pattern pixel stage.
package vga_pkg;

    localparam int unsigned COLOR_W_DEF  = 4;
    localparam int unsigned H_ACTIVE_DEF = 640;
    localparam int unsigned V_ACTIVE_DEF = 480;
    localparam int unsigned HPOS_W       = 10;
    localparam int unsigned VPOS_W       = 9;

    localparam logic [1:0] MODE_BARS     = 2'd0;
    localparam logic [1:0] MODE_CHECKER  = 2'd1;
    localparam logic [1:0] MODE_GRADIENT = 2'd2;
    localparam logic [1:0] MODE_BOX      = 2'd3;

endpackage

// File: rtl/vga_box_mover.sv
// Bouncing-box position: steps once per frame-start strobe and reflects
// at the visible-area edges, clamping onto the edge instead of overshooting.
module vga_box_mover
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
    parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
    parameter int unsigned BOX_SIZE = 32,
    parameter int unsigned STEP     = 2
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              frame_start_i,
    output logic [HPOS_W-1:0] box_x_o,
    output logic [VPOS_W-1:0] box_y_o
);

    localparam int unsigned XMAX = H_ACTIVE - BOX_SIZE;
    localparam int unsigned YMAX = V_ACTIVE - BOX_SIZE;
    localparam int unsigned XW   = HPOS_W + 1;
    localparam int unsigned YW   = VPOS_W + 1;

    logic [HPOS_W-1:0] box_x_q, box_x_d;
    logic [VPOS_W-1:0] box_y_q, box_y_d;
    logic              x_neg_q, x_neg_d;
    logic              y_neg_q, y_neg_d;

    // Compares are one bit wider than the position so pos+STEP cannot wrap.
    always_comb begin
        box_x_d = box_x_q;
        box_y_d = box_y_q;
        x_neg_d = x_neg_q;
        y_neg_d = y_neg_q;
        if (frame_start_i) begin
            if (!x_neg_q) begin
                if (XW'(box_x_q) + XW'(STEP) >= XW'(XMAX)) begin
                    box_x_d = HPOS_W'(XMAX);
                    x_neg_d = 1'b1;
                end else begin
                    box_x_d = box_x_q + HPOS_W'(STEP);
                end
            end else begin
                if (XW'(box_x_q) <= XW'(STEP)) begin
                    box_x_d = '0;
                    x_neg_d = 1'b0;
                end else begin
                    box_x_d = box_x_q - HPOS_W'(STEP);
                end
            end

            if (!y_neg_q) begin
                if (YW'(box_y_q) + YW'(STEP) >= YW'(YMAX)) begin
                    box_y_d = VPOS_W'(YMAX);
                    y_neg_d = 1'b1;
                end else begin
                    box_y_d = box_y_q + VPOS_W'(STEP);
                end
            end else begin
                if (YW'(box_y_q) <= YW'(STEP)) begin
                    box_y_d = '0;
                    y_neg_d = 1'b0;
                end else begin
                    box_y_d = box_y_q - VPOS_W'(STEP);
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            box_x_q <= '0;
            box_y_q <= '0;
            x_neg_q <= 1'b0;
            y_neg_q <= 1'b0;
        end else begin
            box_x_q <= box_x_d;
            box_y_q <= box_y_d;
            x_neg_q <= x_neg_d;
            y_neg_q <= y_neg_d;
        end
    end

    assign box_x_o = box_x_q;
    assign box_y_o = box_y_q;

endmodule

// File: rtl/vga_pattern_gen.sv
// Test-pattern pixel stage: four selectable patterns behind a 2-clock
// pipeline that keeps the syncs aligned with the RGB data.
module vga_pattern_gen
    import vga_pkg::*;
#(
    parameter int unsigned COLOR_W  = COLOR_W_DEF,
    parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
    parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
    parameter int unsigned BOX_SIZE = 32,
    parameter int unsigned STEP     = 2,
    parameter int unsigned CHK_LOG2 = 5
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               hsync_i,
    input  logic               vsync_i,
    input  logic               display_on_i,
    input  logic [HPOS_W-1:0]  hpos_i,
    input  logic [VPOS_W-1:0]  vpos_i,
    input  logic [1:0]         mode_i,
    output logic               hsync_o,
    output logic               vsync_o,
    output logic [COLOR_W-1:0] red_o,
    output logic [COLOR_W-1:0] green_o,
    output logic [COLOR_W-1:0] blue_o
);

    localparam int unsigned XC_W = HPOS_W + 1;
    localparam int unsigned YC_W = VPOS_W + 1;
    localparam logic [COLOR_W-1:0] FS = '1;

    logic               vsync_prev_q;
    logic               frame_start_c;
    logic [1:0]         mode_q, mode_d;
    logic [HPOS_W-1:0]  box_x;
    logic [VPOS_W-1:0]  box_y;
    logic [2:0]         bar_k_c;
    logic [2:0]         bar_code_c;
    logic [HPOS_W-1:0]  pos_xor_c;
    logic               in_box_c;
    logic [COLOR_W-1:0] red_d, green_d, blue_d;
    logic [COLOR_W-1:0] red_s1_q, green_s1_q, blue_s1_q;
    logic               disp_s1_q, hsync_s1_q, vsync_s1_q;
    logic [COLOR_W-1:0] red_q, green_q, blue_q;
    logic               hsync_q, vsync_q;

    assign frame_start_c = vsync_prev_q & ~vsync_i;
    assign mode_d        = frame_start_c ? mode_i : mode_q;

    vga_box_mover #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE),
        .BOX_SIZE (BOX_SIZE),
        .STEP     (STEP)
    ) u_box_mover (
        .clk_i         (clk_i),
        .rst_n_i       (rst_n_i),
        .frame_start_i (frame_start_c),
        .box_x_o       (box_x),
        .box_y_o       (box_y)
    );

    // Bar index = number of eighth-width thresholds already passed.
    always_comb begin
        bar_k_c = '0;
        for (int unsigned n = 1; n < 8; n++) begin
            if (hpos_i >= HPOS_W'(n * H_ACTIVE / 8)) begin
                bar_k_c = bar_k_c + 3'd1;
            end
        end
    end

    assign bar_code_c = 3'd7 - bar_k_c;
    assign pos_xor_c  = hpos_i ^ HPOS_W'(vpos_i);
    assign in_box_c   = (hpos_i >= box_x)
                     && (XC_W'(hpos_i) < XC_W'(box_x) + XC_W'(BOX_SIZE))
                     && (vpos_i >= box_y)
                     && (YC_W'(vpos_i) < YC_W'(box_y) + YC_W'(BOX_SIZE));

    always_comb begin
        red_d   = '0;
        green_d = '0;
        blue_d  = '0;
        case (mode_q)
            MODE_BARS: begin
                red_d   = {COLOR_W{bar_code_c[2]}};
                green_d = {COLOR_W{bar_code_c[1]}};
                blue_d  = {COLOR_W{bar_code_c[0]}};
            end
            MODE_CHECKER: begin
                if (hpos_i[CHK_LOG2] ^ vpos_i[CHK_LOG2]) begin
                    red_d   = FS;
                    green_d = FS;
                    blue_d  = FS;
                end
            end
            MODE_GRADIENT: begin
                red_d   = hpos_i[COLOR_W+3:4];
                green_d = vpos_i[COLOR_W+3:4];
                blue_d  = pos_xor_c[COLOR_W+3:4];
            end
            MODE_BOX: begin
                blue_d = FS;
                if (in_box_c) begin
                    red_d   = FS;
                    green_d = FS;
                end
            end
        endcase
    end

    // Frame-start detection and mode latch.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            vsync_prev_q <= 1'b1;
            mode_q       <= MODE_BARS;
        end else begin
            vsync_prev_q <= vsync_i;
            mode_q       <= mode_d;
        end
    end

    // Two-stage pipeline; blanking is applied on the second stage.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            red_s1_q   <= '0;
            green_s1_q <= '0;
            blue_s1_q  <= '0;
            disp_s1_q  <= 1'b0;
            hsync_s1_q <= 1'b1;
            vsync_s1_q <= 1'b1;
            red_q      <= '0;
            green_q    <= '0;
            blue_q     <= '0;
            hsync_q    <= 1'b1;
            vsync_q    <= 1'b1;
        end else begin
            red_s1_q   <= red_d;
            green_s1_q <= green_d;
            blue_s1_q  <= blue_d;
            disp_s1_q  <= display_on_i;
            hsync_s1_q <= hsync_i;
            vsync_s1_q <= vsync_i;
            red_q      <= disp_s1_q ? red_s1_q   : '0;
            green_q    <= disp_s1_q ? green_s1_q : '0;
            blue_q     <= disp_s1_q ? blue_s1_q  : '0;
            hsync_q    <= hsync_s1_q;
            vsync_q    <= vsync_s1_q;
        end
    end

    assign hsync_o = hsync_q;
    assign vsync_o = vsync_q;
    assign red_o   = red_q;
    assign green_o = green_q;
    assign blue_o  = blue_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Bench for vga_pattern_gen: two instances (STEP 2 and STEP 5) against an
// arithmetic pixel model, with literal pins on the model's bounce points.
module tb_vga_pattern_gen;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       hsync_i, vsync_i, display_on_i;
    logic [9:0] hpos_i;
    logic [8:0] vpos_i;
    logic [1:0] mode_i;
    logic       hs_a, vs_a, hs_b, vs_b;
    logic [3:0] r_a, g_a, b_a, r_b, g_b, b_b;

    always #5 clk = ~clk;

    vga_pattern_gen #(.STEP(2)) u_dut_a (
        .clk_i(clk), .rst_n_i(rst_n), .hsync_i(hsync_i), .vsync_i(vsync_i),
        .display_on_i(display_on_i), .hpos_i(hpos_i), .vpos_i(vpos_i),
        .mode_i(mode_i), .hsync_o(hs_a), .vsync_o(vs_a),
        .red_o(r_a), .green_o(g_a), .blue_o(b_a)
    );

    vga_pattern_gen #(.STEP(5)) u_dut_b (
        .clk_i(clk), .rst_n_i(rst_n), .hsync_i(hsync_i), .vsync_i(vsync_i),
        .display_on_i(display_on_i), .hpos_i(hpos_i), .vpos_i(vpos_i),
        .mode_i(mode_i), .hsync_o(hs_b), .vsync_o(vs_b),
        .red_o(r_b), .green_o(g_b), .blue_o(b_b)
    );

    typedef struct {
        logic        hs;
        logic        vs;
        logic [11:0] rgb_a;
        logic [11:0] rgb_b;
    } exp_t;

    exp_t expq[$];
    int   checks = 0;
    int   errors = 0;

    // Model state: latched mode, box positions/directions per instance.
    int m_mode;
    int bx[2];
    int by[2];
    bit bxneg[2];
    bit byneg[2];
    bit m_prev_vs;
    int frame_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [11:0] pattern(input int md, input int h, input int v,
                                            input int bxp, input int byp);
        logic [2:0] c;
        logic [3:0] gr, gg, gb;
        case (md)
            0: begin
                c = (h >= 640) ? 3'd0 : 3'(7 - h / 80);
                return {{4{c[2]}}, {4{c[1]}}, {4{c[0]}}};
            end
            1: return ((((h >> 5) ^ (v >> 5)) & 1) != 0) ? 12'hFFF : 12'h000;
            2: begin
                gr = 4'(h >> 4);
                gg = 4'(v >> 4);
                gb = 4'((h ^ v) >> 4);
                return {gr, gg, gb};
            end
            default: return (h >= bxp && h < bxp + 32 && v >= byp && v < byp + 32)
                            ? 12'hFFF : 12'h00F;
        endcase
    endfunction

    function automatic void axis_step(inout int pos, inout bit neg, input int step, input int maxv);
        if (!neg) begin
            if (pos + step >= maxv) begin pos = maxv; neg = 1'b1; end
            else pos = pos + step;
        end else begin
            if (pos <= step) begin pos = 0; neg = 1'b0; end
            else pos = pos - step;
        end
    endfunction

    function automatic exp_t rst_entry();
        exp_t e;
        e.hs = 1'b1; e.vs = 1'b1; e.rgb_a = '0; e.rgb_b = '0;
        return e;
    endfunction

    function automatic void model_reset();
        m_mode = 0; m_prev_vs = 1'b1; frame_cnt = 0;
        for (int i = 0; i < 2; i++) begin
            bx[i] = 0; by[i] = 0; bxneg[i] = 1'b0; byneg[i] = 1'b0;
        end
    endfunction

    // One clock of stimulus; the model records what the outputs must be 2 clk later.
    task automatic cyc(input bit rst, input bit hs, input bit vs, input bit de,
                       input int h, input int v, input int md);
        exp_t e;
        rst_n = rst; hsync_i = hs; vsync_i = vs; display_on_i = de;
        hpos_i = 10'(h); vpos_i = 9'(v); mode_i = 2'(md);
        if (!rst) begin
            e = rst_entry();
            model_reset();
        end else begin
            e.hs = hs; e.vs = vs;
            e.rgb_a = de ? pattern(m_mode, h, v, bx[0], by[0]) : 12'h000;
            e.rgb_b = de ? pattern(m_mode, h, v, bx[1], by[1]) : 12'h000;
            if (m_prev_vs && !vs) begin
                m_mode = md;
                axis_step(bx[0], bxneg[0], 2, 608);
                axis_step(by[0], byneg[0], 2, 448);
                axis_step(bx[1], bxneg[1], 5, 608);
                axis_step(by[1], byneg[1], 5, 448);
                frame_cnt++;
            end
            m_prev_vs = vs;
        end
        expq.push_back(e);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin : compare
        exp_t e;
        if (expq.size() >= 3) begin
            e = expq.pop_front();
            chk("hsync_a", 32'(hs_a), 32'(e.hs));
            chk("vsync_a", 32'(vs_a), 32'(e.vs));
            chk("hsync_b", 32'(hs_b), 32'(e.hs));
            chk("vsync_b", 32'(vs_b), 32'(e.vs));
            chk("rgb_a", 32'({r_a, g_a, b_a}), 32'(e.rgb_a));
            chk("rgb_b", 32'({r_b, g_b, b_b}), 32'(e.rgb_b));
        end
    end

    task automatic frame_start_seq(input int md);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 700, 490, md);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 710, 491, md);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 720, 492, md);
    endtask

    task automatic rand_frame();
        int md, k, h, v, sel;
        bit de;
        md = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2)) : 3;
        frame_start_seq(md);
        for (int i = 0; i < 12; i++) begin
            k = int'($urandom_range(0, 1));
            if (m_mode == 3 && $urandom_range(0, 2) != 0) begin
                sel = int'($urandom_range(0, 3));
                h = bx[k] + ((sel == 0) ? -1 : (sel == 1) ? 0 : (sel == 2) ? 31 : 32);
                sel = int'($urandom_range(0, 4));
                v = by[k] + ((sel == 0) ? -1 : (sel == 1) ? 0 : (sel == 2) ? 31 :
                             (sel == 3) ? 32 : 15);
                h = (h < 0) ? 0 : (h > 639) ? 639 : h;
                v = (v < 0) ? 0 : (v > 479) ? 479 : v;
            end else begin
                h = int'($urandom_range(0, 799));
                v = int'($urandom_range(0, 511));
            end
            de = (h < 640) && (v < 480);
            if ($urandom_range(0, 7) == 0) de = ~de;
            cyc(1'b1, 1'($urandom_range(0, 1)), 1'b1, de, h, v, int'($urandom_range(0, 3)));
        end
    endtask

    initial begin
        model_reset();
        // Model pins against hand-computed pixels.
        chk("pin bars h0",    32'(pattern(0, 0, 10, 0, 0)),     32'h0FFF);
        chk("pin bars h80",   32'(pattern(0, 80, 10, 0, 0)),    32'h0FF0);
        chk("pin bars h639",  32'(pattern(0, 639, 10, 0, 0)),   32'h0000);
        chk("pin chk v32h0",  32'(pattern(1, 0, 32, 0, 0)),     32'h0FFF);
        chk("pin chk v32h32", 32'(pattern(1, 32, 32, 0, 0)),    32'h0000);
        chk("pin grad",       32'(pattern(2, 'hF0, 'h50, 0, 0)), 32'h0F5A);

        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b1, 1'b0, 100 + i, 5, 0);
        chk("reset hsync", 32'(hs_a), 32'h1);
        chk("reset rgb",   32'({r_a, g_a, b_a}), 32'h0);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b1, 1'b0, 700, 495, 0);

        // Bars, with a toggling hsync for the 2-clock alignment.
        frame_start_seq(0);
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 0, 10, 0);
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 80, 10, 0);
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 639, 10, 0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 700, 10, 0);
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 300, 10, 0);

        // Checker with blanking over a white checker cell.
        frame_start_seq(1);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 700, 0, 1);
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 0, 32, 1);
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 32, 32, 1);

        // Mid-frame mode change ignored until the next frame start.
        frame_start_seq(0);
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 0, 100, 2);
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 80, 100, 2);
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 'hF0, 100, 2);
        frame_start_seq(2);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b1, 1'b1, 'hF0, 'h50, 2);

        // Asynchronous reset mid-line.
        #2 rst_n = 1'b0;
        #1;
        chk("async rst hsync_a", 32'(hs_a), 32'h1);
        chk("async rst vsync_a", 32'(vs_a), 32'h1);
        chk("async rst rgb_a",   32'({r_a, g_a, b_a}), 32'h0);
        chk("async rst rgb_b",   32'({r_b, g_b, b_b}), 32'h0);
        foreach (expq[i]) expq[i] = rst_entry();
        expq.push_back(rst_entry());
        model_reset();
        @(posedge clk);
        #1;
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 'hF0, 'h50, 2);
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 0, 10, 2);
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 80, 10, 2);

        // Bouncing box over enough frames to hit every clamp point.
        for (int f = 0; f < 310; f++) begin
            rand_frame();
            case (frame_cnt)
                121: chk("model b x f121", 32'(bx[1]), 32'd605);
                122: begin
                    chk("model b x f122",   32'(bx[1]), 32'd608);
                    chk("model b dir f122", 32'(bxneg[1]), 32'd1);
                end
                224: chk("model a y f224", 32'(by[0]), 32'd448);
                225: chk("model a y f225", 32'(by[0]), 32'd446);
                243: chk("model b x f243", 32'(bx[1]), 32'd3);
                244: begin
                    chk("model b x f244",   32'(bx[1]), 32'd0);
                    chk("model b dir f244", 32'(bxneg[1]), 32'd0);
                end
                304: begin
                    chk("model a x f304",   32'(bx[0]), 32'd608);
                    chk("model a dir f304", 32'(bxneg[0]), 32'd1);
                end
                305: chk("model a x f305", 32'(bx[0]), 32'd606);
                default: ;
            endcase
        end

        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 1'b1, 1'b0, 700, 10, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
